auto_att_ctrl: RTL and testbench

AUTO_ATT_CTRL -- requirements
Module: auto_att_ctrl

---
 rtl/auto_att_pkg.sv | 21 ++
 rtl/auto_att_ctrl_cdc_sync.sv | 23 ++
 rtl/auto_att_ctrl.sv | 127 ++++++++++++
 tb/tb_auto_att_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/auto_att_pkg.sv
// Shared types and constants for the automatic attenuator controller.
package auto_att_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    DECAY
  } state_t;

  localparam int ATT_W   = 5;
  localparam int ATT_MAX = 31;
  localparam int TIMER_W = 32;

  // Saturating add so an attack near full scale pins at ATT_MAX instead of wrapping.
  function automatic logic [ATT_W-1:0] sat_add(input logic [ATT_W-1:0] a, input int step);
    int sum;
    sum = int'(a) + step;
    return (sum > ATT_MAX) ? ATT_W'(ATT_MAX) : ATT_W'(sum);
  endfunction

endpackage

// File: rtl/auto_att_ctrl_cdc_sync.sv
// Two-flop synchronizer for asynchronous level inputs.
module cdc_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/auto_att_ctrl.sv
// Automatic attenuation control: step up on ADC overrange, hold, then release 1 dB at a time.
// Defining AUTO_ATT_CLIP_LED_EN adds a clip indicator stretched by its own timer.
module auto_att_ctrl
  import auto_att_pkg::*;
#(
  parameter int STEP_DB      = 3,
  parameter int HOLD_CYCLES  = 40000,
  parameter int DECAY_CYCLES = 20000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             auto_en,
  input  logic             adc_overrange,
  input  logic [ATT_W-1:0] manual_att,
  input  logic             att_busy,
  output logic [ATT_W-1:0] att_value,
  output logic             att_load,
  output logic             clip_led
);

  logic               ovf;
  state_t             state;
  logic [ATT_W-1:0]   cur_att;
  logic [ATT_W-1:0]   floor_att;
  logic [ATT_W-1:0]   next_att;
  logic               pending;
  logic               load_now;
  logic               auto_mode;
  logic               timer_done;
  logic [TIMER_W-1:0] timer;

  cdc_sync #(.WIDTH(1)) ovf_sync (
    .clock(clock),
    .reset(reset),
    .d    (adc_overrange),
    .q    (ovf)
  );

  // manual_att acts as a floor, so attacks and releases are computed from the raised value.
  always_comb begin
    auto_mode  = run && auto_en;
    load_now   = pending && !att_busy;
    timer_done = timer <= TIMER_W'(1);
    floor_att  = (manual_att > cur_att) ? manual_att : cur_att;
    next_att   = floor_att;
    if (!auto_mode)
      next_att = manual_att;
    else if (ovf)
      next_att = pending ? floor_att : sat_add(floor_att, STEP_DB);
    else if (state == DECAY && floor_att != manual_att && timer_done)
      next_att = floor_att - ATT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      cur_att   <= '0;
      pending   <= 1'b1;
      timer     <= '0;
      att_value <= '0;
      att_load  <= 1'b0;
    end else begin
      att_load <= load_now;
      if (load_now)
        att_value <= cur_att;
      cur_att <= next_att;
      // A change landing on a load cycle keeps pending so the newer value follows.
      pending <= (pending && !load_now) || (next_att != cur_att);
      if (!auto_mode) begin
        state <= IDLE;
        timer <= '0;
      end else if (ovf) begin
        state <= HOLD;
        timer <= TIMER_W'(HOLD_CYCLES);
      end else begin
        case (state)
          HOLD: begin
            if (timer_done) begin
              if (floor_att > manual_att) begin
                state <= DECAY;
                timer <= TIMER_W'(DECAY_CYCLES);
              end else begin
                state <= IDLE;
                timer <= '0;
              end
            end else begin
              timer <= timer - TIMER_W'(1);
            end
          end
          DECAY: begin
            if (floor_att == manual_att || (timer_done && next_att == manual_att)) begin
              state <= IDLE;
              timer <= '0;
            end else if (timer_done) begin
              timer <= TIMER_W'(DECAY_CYCLES);
            end else begin
              timer <= timer - TIMER_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

`ifdef AUTO_ATT_CLIP_LED_EN
  logic [TIMER_W-1:0] led_timer;

  always_ff @(posedge clock) begin
    if (!reset || !run)
      led_timer <= '0;
    else if (ovf)
      led_timer <= TIMER_W'(HOLD_CYCLES);
    else if (led_timer != '0)
      led_timer <= led_timer - TIMER_W'(1);
  end

  assign clip_led = reset && run && (led_timer != '0);
`else
  assign clip_led = 1'b0;
`endif

endmodule

// File: tb/tb_auto_att_ctrl.sv
// Randomized self-checking bench for auto_att_ctrl against a behavioural reference model.
`timescale 1ns/1ps
module tb_auto_att_ctrl;

  localparam int STEP    = 3;
  localparam int H       = 40;
  localparam int D       = 20;
  localparam int M_IDLE  = 0;
  localparam int M_HOLD  = 1;
  localparam int M_DECAY = 2;

  logic       clock;
  logic       reset;
  logic       run;
  logic       auto_en;
  logic       adc_overrange;
  logic [4:0] manual_att;
  logic       att_busy;
  logic [4:0] att_value;
  logic       att_load;
  logic       clip_led;

  int check_count = 0;
  int pass_count  = 0;
  bit check_en    = 0;

  int m_s1, m_s2, m_mode, m_cur, m_pend, m_hold, m_decay, m_val, m_load, m_led;

  auto_att_ctrl #(
    .STEP_DB     (STEP),
    .HOLD_CYCLES (H),
    .DECAY_CYCLES(D)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .run          (run),
    .auto_en      (auto_en),
    .adc_overrange(adc_overrange),
    .manual_att   (manual_att),
    .att_busy     (att_busy),
    .att_value    (att_value),
    .att_load     (att_load),
    .clip_led     (clip_led)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected)
      pass_count++;
    else
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input bit r, input bit ru, input bit ae, input bit ov,
                               input int man, input bit bz);
    reset         = r;
    run           = ru;
    auto_en       = ae;
    adc_overrange = ov;
    manual_att    = 5'(man);
    att_busy      = bz;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulseOvf();
    adc_overrange = 1'b1;
    @(negedge clock);
    adc_overrange = 1'b0;
  endtask

  task automatic waitLoad(input int limit, output int cycles, output int val, output bit found);
    found  = 0;
    cycles = 0;
    val    = 0;
    while (!found && cycles < limit) begin
      @(negedge clock);
      cycles++;
      if (att_load === 1'b1) begin
        found = 1;
        val   = int'(att_value);
      end
    end
  endtask

  // Reference model: one step per clock from the rules for attack, hold, release and loading.
  always @(posedge clock) begin
    int ovf_now, fl, old_cur, man, load_now;
    if (!reset) begin
      m_s1 = 0; m_s2 = 0; m_mode = M_IDLE; m_cur = 0; m_pend = 1;
      m_hold = 0; m_decay = 0; m_val = 0; m_load = 0; m_led = 0;
    end else begin
      ovf_now  = m_s2;
      m_s2     = m_s1;
      m_s1     = int'(adc_overrange);
      man      = int'(manual_att);
      old_cur  = m_cur;
      load_now = (m_pend != 0 && !att_busy) ? 1 : 0;
      fl       = (man > m_cur) ? man : m_cur;
      if (!run || !auto_en) begin
        m_cur = man; m_mode = M_IDLE; m_hold = 0; m_decay = 0;
      end else if (ovf_now != 0) begin
        m_cur  = (m_pend != 0) ? fl : ((fl + STEP > 31) ? 31 : fl + STEP);
        m_mode = M_HOLD;
        m_hold = H;
      end else if (m_mode == M_HOLD) begin
        m_cur = fl;
        m_hold--;
        if (m_hold == 0) begin
          if (fl > man) begin m_mode = M_DECAY; m_decay = D; end
          else m_mode = M_IDLE;
        end
      end else if (m_mode == M_DECAY) begin
        m_cur = fl;
        if (fl == man) m_mode = M_IDLE;
        else begin
          m_decay--;
          if (m_decay == 0) begin
            m_cur   = fl - 1;
            m_decay = D;
            if (m_cur == man) m_mode = M_IDLE;
          end
        end
      end else begin
        m_cur = fl;
      end
      m_load = load_now;
      if (load_now != 0) m_val = old_cur;
      m_pend = ((m_pend != 0 && load_now == 0) || m_cur != old_cur) ? 1 : 0;
`ifdef AUTO_ATT_CLIP_LED_EN
      if (!run) m_led = 0;
      else if (ovf_now != 0) m_led = H;
      else if (m_led > 0) m_led--;
`endif
    end
  end

  always begin
    int exp_clip;
    @(negedge clock);
    #1;
    if (check_en) begin
`ifdef AUTO_ATT_CLIP_LED_EN
      exp_clip = (reset && run && m_led > 0) ? 1 : 0;
`else
      exp_clip = 0;
`endif
      checkOutput("model_att_load", 32'(att_load), 32'(m_load));
      checkOutput("model_att_value", 32'(att_value), 32'(m_val));
      checkOutput("model_clip_led", 32'(clip_led), 32'(exp_clip));
    end
  end

  initial begin
    int cyc, val;
    bit found;
    int led_len;
    applyStimulus(0, 1, 0, 0, 6, 0);
    tick(3);
    check_en = 1;
    checkOutput("reset_att_load", 32'(att_load), 0);
    checkOutput("reset_att_value", 32'(att_value), 0);
    checkOutput("reset_clip_led", 32'(clip_led), 0);

    // Release: first load carries the reset value, second the tracked manual value.
    reset = 1'b1;
    @(negedge clock);
    checkOutput("first_load_strobe", 32'(att_load), 1);
    checkOutput("first_load_value", 32'(att_value), 0);
    @(negedge clock);
    checkOutput("second_load_strobe", 32'(att_load), 1);
    checkOutput("second_load_value", 32'(att_value), 6);

    manual_att = 5'd0;
    tick(5);
    auto_en = 1'b1;
    tick(3);
    pulseOvf();
    waitLoad(10, cyc, val, found);
    checkOutput("attack_seen", 32'(found), 1);
    checkOutput("attack_value", 32'(val), 3);
    waitLoad(H + D + 10, cyc, val, found);
    checkOutput("release1_interval", 32'(cyc), H + D);
    checkOutput("release1_value", 32'(val), 2);
    waitLoad(D + 10, cyc, val, found);
    checkOutput("release2_interval", 32'(cyc), D);
    checkOutput("release2_value", 32'(val), 1);
    waitLoad(D + 10, cyc, val, found);
    checkOutput("release3_interval", 32'(cyc), D);
    checkOutput("release3_value", 32'(val), 0);
    waitLoad(3 * D, cyc, val, found);
    checkOutput("idle_no_load", 32'(found), 0);

    auto_en    = 1'b0;
    manual_att = 5'd30;
    tick(5);
    auto_en = 1'b1;
    tick(2);
    pulseOvf();
    waitLoad(10, cyc, val, found);
    checkOutput("saturate_value", 32'(val), 31);
    pulseOvf();
    waitLoad(10, cyc, val, found);
    checkOutput("saturate_no_reload", 32'(found), 0);
    checkOutput("saturate_hold_value", 32'(att_value), 31);

    auto_en    = 1'b0;
    manual_att = 5'd0;
    tick(5);
    auto_en  = 1'b1;
    tick(2);
    att_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pulseOvf();
      tick(15);
    end
    tick(20);
    att_busy = 1'b0;
    waitLoad(10, cyc, val, found);
    checkOutput("busy_release_latency", 32'(cyc), 1);
    checkOutput("busy_single_step", 32'(val), 3);

    auto_en    = 1'b0;
    manual_att = 5'd6;
    tick(5);
    auto_en = 1'b1;
    tick(2);
    pulseOvf();
    waitLoad(10, cyc, val, found);
    checkOutput("decay_setup_value", 32'(val), 9);
    manual_att = 5'd4;
    tick(45);
    auto_en = 1'b0;
    waitLoad(5, cyc, val, found);
    checkOutput("abort_latency", 32'(cyc), 2);
    checkOutput("abort_value", 32'(val), 4);

    tick(5);
`ifdef AUTO_ATT_CLIP_LED_EN
    pulseOvf();
    waitLoad(0, cyc, val, found);
    cyc = 0;
    while (clip_led !== 1'b1 && cyc < 10) begin
      @(negedge clock);
      cyc++;
    end
    checkOutput("clip_seen", 32'(clip_led), 1);
    led_len = 0;
    while (clip_led === 1'b1 && led_len < H + 20) begin
      led_len++;
      @(negedge clock);
    end
    checkOutput("clip_length", 32'(led_len), H);
    pulseOvf();
    tick(5);
    run = 1'b0;
    #1;
    checkOutput("clip_run_clear", 32'(clip_led), 0);
    tick(3);
    run = 1'b1;
    tick(3);
`else
    led_len = 0;
    pulseOvf();
    tick(5);
    checkOutput("clip_disabled", 32'(clip_led), 32'(led_len));
`endif

    for (int i = 0; i < 3000; i++) begin
      int rate;
      bit ov, ru, ae, rs;
      @(negedge clock);
      rate = (i / 300) % 3;
      ov = (rate == 1) ? ($urandom_range(0, 99) == 0) : (rate == 2) ? ($urandom_range(0, 9) == 0) : 1'b0;
      ru = ($urandom_range(0, 199) == 0) ? !run : run;
      ae = ($urandom_range(0, 149) == 0) ? !auto_en : auto_en;
      rs = ($urandom_range(0, 699) != 0);
      applyStimulus(rs, ru, ae, ov,
                    ($urandom_range(0, 49) == 0) ? int'($urandom_range(0, 31)) : int'(manual_att),
                    $urandom_range(0, 2) == 0);
    end
    applyStimulus(1, 1, 0, 0, 0, 0);
    tick(5);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
